// File: rtl/lyr2_seq.sv
// Layer sequencer: feeds one shared 2-input neuron datapath once per neuron,
// fetching w1/w2/b from a weight ROM and streaming {idx, result} downstream.
// Handshakes: a transfer happens on any rising edge where valid and ready
// are both high; a producer holds its data stable while valid is high and
// ready is low, and a consumer never depends on data without valid.
module lyr2_seq #(
    parameter int N_NEURON = 4,
    parameter int ADDR_W   = 2,
    parameter int DW       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_d1,
    input  logic [DW-1:0]     in_d2,
    output logic [ADDR_W-1:0] wb_addr,
    input  logic [DW-1:0]     wb_w1,
    input  logic [DW-1:0]     wb_w2,
    input  logic [DW-1:0]     wb_b,
    output logic [DW-1:0]     dp_d1,
    output logic [DW-1:0]     dp_d2,
    output logic [DW-1:0]     dp_w1,
    output logic [DW-1:0]     dp_w2,
    output logic [DW-1:0]     dp_b,
    input  logic [DW-1:0]     dp_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DW-1:0]     out_data,
    output logic              busy,
    output logic              done
);

    // Neuron count must fit the ROM address space and be non-empty.
    if (N_NEURON < 1 || N_NEURON > (2 ** ADDR_W)) begin : g_bad_n_neuron
        $error("lyr2_seq: N_NEURON out of range 1 .. 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURON - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // Handshake/status views decoded straight from the state register.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign wb_addr  = idx;

    // Single sequencing FSM; all datapath operands and stream outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            dp_d1     <= '0;
            dp_d2     <= '0;
            dp_w1     <= '0;
            dp_w2     <= '0;
            dp_b      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The input vector is captured once and reused by every neuron.
                    if (in_valid) begin
                        dp_d1 <= in_d1;
                        dp_d2 <= in_d2;
                        idx   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // ROM words for wb_addr == idx are sampled at the end of this cycle.
                    dp_w1 <= wb_w1;
                    dp_w2 <= wb_w2;
                    dp_b  <= wb_b;
                    state <= EVAL;
                end
                EVAL: begin
                    // Operands have been stable for a full cycle; latch the datapath result.
                    out_data  <= dp_res;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    // Hold the result until downstream accepts it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lyr2_seq.sv
// Directed bench for lyr2_seq: a 4-neuron instance and a 1-neuron instance,
// each with a stub weight ROM and a stub datapath (dp_res = dp_b ^ dp_d1).
module tb_lyr2_seq;

    localparam int DW = 16;
    localparam int AW = 2;

    logic clk;
    logic rst;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4-neuron instance ----------------
    logic          in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [DW-1:0] in_d1, in_d2, wb_w1, wb_w2, wb_b;
    logic [DW-1:0] dp_d1, dp_d2, dp_w1, dp_w2, dp_b, dp_res, out_data;
    logic [AW-1:0] wb_addr, out_idx;

    lyr2_seq #(.N_NEURON(4), .ADDR_W(AW), .DW(DW)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_d1(in_d1), .in_d2(in_d2),
        .wb_addr(wb_addr), .wb_w1(wb_w1), .wb_w2(wb_w2), .wb_b(wb_b),
        .dp_d1(dp_d1), .dp_d2(dp_d2), .dp_w1(dp_w1), .dp_w2(dp_w2), .dp_b(dp_b),
        .dp_res(dp_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .busy(busy), .done(done)
    );

    // ---------------- 1-neuron instance ----------------
    logic          one_in_valid, one_in_ready, one_out_valid, one_out_ready, one_busy, one_done;
    logic [DW-1:0] one_in_d1, one_in_d2, one_wb_w1, one_wb_w2, one_wb_b;
    logic [DW-1:0] one_dp_d1, one_dp_d2, one_dp_w1, one_dp_w2, one_dp_b, one_dp_res, one_out_data;
    logic [AW-1:0] one_wb_addr, one_out_idx;

    lyr2_seq #(.N_NEURON(1), .ADDR_W(AW), .DW(DW)) u_one (
        .clk(clk), .rst(rst),
        .in_valid(one_in_valid), .in_ready(one_in_ready), .in_d1(one_in_d1), .in_d2(one_in_d2),
        .wb_addr(one_wb_addr), .wb_w1(one_wb_w1), .wb_w2(one_wb_w2), .wb_b(one_wb_b),
        .dp_d1(one_dp_d1), .dp_d2(one_dp_d2), .dp_w1(one_dp_w1), .dp_w2(one_dp_w2), .dp_b(one_dp_b),
        .dp_res(one_dp_res),
        .out_valid(one_out_valid), .out_ready(one_out_ready), .out_idx(one_out_idx),
        .out_data(one_out_data), .busy(one_busy), .done(one_done)
    );

    // ---------------- ROM and datapath stubs ----------------
    function automatic logic [DW-1:0] rom_w1(input logic [AW-1:0] a);
        return 16'h0010 * (16'(a) + 16'd1);
    endfunction
    function automatic logic [DW-1:0] rom_w2(input logic [AW-1:0] a);
        return 16'h0020 * (16'(a) + 16'd1);
    endfunction
    function automatic logic [DW-1:0] rom_b(input logic [AW-1:0] a);
        return 16'h0100 * (16'(a) + 16'd1);
    endfunction

    // ROM words are ready before the edge that closes FETCH.
    always_comb begin
        wb_w1      = rom_w1(wb_addr);
        wb_w2      = rom_w2(wb_addr);
        wb_b       = rom_b(wb_addr);
        one_wb_w1  = rom_w1(one_wb_addr);
        one_wb_w2  = rom_w2(one_wb_addr);
        one_wb_b   = rom_b(one_wb_addr);
        dp_res     = dp_b ^ dp_d1;
        one_dp_res = one_dp_b ^ one_dp_d1;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_d1 = '0; in_d2 = '0; out_ready = 1'b1;
        one_in_valid = 1'b0; one_in_d1 = '0; one_in_d2 = '0; one_out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dp_d1", 32'(dp_d1), 32'd0);
        chk("rst_dp_b", 32'(dp_b), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_one_in_ready", 32'(one_in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Nominal layer: accept at E0, handshakes at E3/E6/E9/E12
        in_valid = 1'b1; in_d1 = 16'h0003; in_d2 = 16'h0005;
        tick();
        in_valid = 1'b0;
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_in_ready", 32'(in_ready), 32'd0);
        chk("acc_dp_d1", 32'(dp_d1), 32'h0003);
        chk("acc_dp_d2", 32'(dp_d2), 32'h0005);
        for (int k = 0; k < 4; k++) begin
            chk("nom_wb_addr", 32'(wb_addr), 32'(k));
            tick();
            chk("nom_dp_w1", 32'(dp_w1), 32'(rom_w1(AW'(k))));
            chk("nom_dp_w2", 32'(dp_w2), 32'(rom_w2(AW'(k))));
            chk("nom_dp_b", 32'(dp_b), 32'(rom_b(AW'(k))));
            chk("nom_early_valid", 32'(out_valid), 32'd0);
            tick();
            chk("nom_valid", 32'(out_valid), 32'd1);
            chk("nom_idx", 32'(out_idx), 32'(k));
            chk("nom_data", 32'(out_data), 32'h0103 + 32'h0100 * 32'(k));
            tick();
            chk("nom_valid_drop", 32'(out_valid), 32'd0);
            chk("nom_done", 32'(done), (k == 3) ? 32'd1 : 32'd0);
            chk("nom_in_ready", 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("nom_done_pulse_end", 32'(done), 32'd0);

        // Backpressure on neuron 1 with a busy-time input vector held
        in_valid = 1'b1; in_d1 = 16'h0003; in_d2 = 16'h0005;
        tick();
        in_d1 = 16'hFFFF; in_d2 = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_idx", 32'(out_idx), 32'(k));
            chk("bp_data", 32'(out_data), 32'h0103 + 32'h0100 * 32'(k));
            if (k == 1) begin
                out_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    chk("bp_hold_valid", 32'(out_valid), 32'd1);
                    chk("bp_hold_idx", 32'(out_idx), 32'd1);
                    chk("bp_hold_data", 32'(out_data), 32'h0203);
                    chk("busy_in_ready", 32'(in_ready), 32'd0);
                    chk("busy_dp_d1", 32'(dp_d1), 32'h0003);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("bp_end_in_ready", 32'(in_ready), 32'd1);
        chk("bp_end_dp_d1", 32'(dp_d1), 32'h0003);
        tick();
        chk("held_vec_acc_busy", 32'(busy), 32'd1);
        chk("held_vec_dp_d1", 32'(dp_d1), 32'hFFFF);

        // Run neurons 0 and 1 of the held vector, then reset during EVAL of neuron 2
        for (int k = 0; k < 2; k++) begin
            tick();
            tick();
            chk("ff_data", 32'(out_data), 32'(rom_b(AW'(k)) ^ 16'hFFFF));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("eval2_valid", 32'(out_valid), 32'd0);
        chk("eval2_dp_b", 32'(dp_b), 32'h0300);
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_dp_d1", 32'(dp_d1), 32'd0);
        chk("mrst_dp_w1", 32'(dp_w1), 32'd0);
        chk("mrst_dp_b", 32'(dp_b), 32'd0);
        chk("mrst_out_data", 32'(out_data), 32'd0);
        chk("mrst_out_idx", 32'(out_idx), 32'd0);
        chk("mrst_wb_addr", 32'(wb_addr), 32'd0);
        tick();
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            tick();
            chk("post_rst_no_out", 32'(out_valid), 32'd0);
        end

        // Fresh layer after reset starts at idx 0
        in_valid = 1'b1; in_d1 = 16'h0003; in_d2 = 16'h0005;
        tick();
        in_valid = 1'b0;
        chk("restart_addr", 32'(wb_addr), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            chk("restart_idx", 32'(out_idx), 32'(k));
            chk("restart_data", 32'(out_data), 32'h0103 + 32'h0100 * 32'(k));
            tick();
        end
        chk("restart_done", 32'(done), 32'd1);

        // Single-neuron config, vectors offered back to back
        one_in_valid = 1'b1; one_in_d1 = 16'h0003; one_in_d2 = 16'h0005;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("one_acc_busy", 32'(one_busy), 32'd1);
            chk("one_dp_d1", 32'(one_dp_d1), 32'h0003);
            tick();
            chk("one_early_valid", 32'(one_out_valid), 32'd0);
            tick();
            chk("one_valid", 32'(one_out_valid), 32'd1);
            chk("one_idx", 32'(one_out_idx), 32'd0);
            chk("one_data", 32'(one_out_data), 32'h0103);
            tick();
            chk("one_done", 32'(one_done), 32'd1);
            chk("one_in_ready", 32'(one_in_ready), 32'd1);
            chk("one_valid_drop", 32'(one_out_valid), 32'd0);
        end
        one_in_valid = 1'b0;
        tick();
        chk("one_done_end", 32'(one_done), 32'd0);
        chk("one_idle", 32'(one_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lyr2_seq.md
Name: lyr2_seq

Overview:
- Time-multiplexed sequencer for one shared 2-input neuron datapath (two 16-bit multipliers, adder, sigmoid; combinational, outside this block).
- Accepts one 2-element input vector and evaluates N_NEURON neurons serially, one per pass through the datapath.
- Fetches each neuron's w1/w2/b from a synchronous weight ROM and streams {index, result} out over a valid/ready port.
- Sits between the previous layer's output stream and the next layer's input buffer.

Parameters:
- N_NEURON, 4, neurons per layer; legal range 1 .. 2**ADDR_W (elaboration-time check).
- ADDR_W, 2, weight-ROM address width and out_idx width.
- DW, 16, data/weight/bias/result width (fixed-point, passed through unmodified).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector; equals (state==IDLE).
- in_d1  in  DW  input element 1.
- in_d2  in  DW  input element 2.
- wb_addr  out  ADDR_W  weight-ROM address; equals idx.
- wb_w1  in  DW  ROM weight 1; valid 1 cycle after wb_addr.
- wb_w2  in  DW  ROM weight 2; valid 1 cycle after wb_addr.
- wb_b  in  DW  ROM bias; valid 1 cycle after wb_addr.
- dp_d1  out  DW  registered datapath operand d1.
- dp_d2  out  DW  registered datapath operand d2.
- dp_w1  out  DW  registered datapath operand w1.
- dp_w2  out  DW  registered datapath operand w2.
- dp_b  out  DW  registered datapath operand b.
- dp_res  in  DW  datapath result, combinational from the dp_* operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_idx  out  ADDR_W  index of the neuron whose result is on out_data.
- out_data  out  DW  captured dp_res.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on the final handshake of a layer.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, idx = 0.
  - All dp_* = 0, out_data = 0, out_idx = 0.
  - out_valid = 0, done = 0, busy = 0.
  - in_ready = 1 while in IDLE; no handshake is registered while rst is high.
- FSM states: IDLE, FETCH, EVAL, EMIT.
- IDLE:
  - On in_valid & in_ready at an edge: dp_d1 <= in_d1, dp_d2 <= in_d2, idx <= 0, go to FETCH.
  - in_d1/in_d2 are not sampled again during the layer.
- FETCH (1 cycle):
  - wb_addr = idx is presented.
  - At the next edge: dp_w1/dp_w2/dp_b <= wb_w1/wb_w2/wb_b, go to EVAL.
- EVAL (1 cycle):
  - The datapath settles on the registered operands.
  - At the next edge: out_data <= dp_res, out_idx <= idx, out_valid <= 1, go to EMIT.
- EMIT:
  - out_valid = 1; out_data and out_idx held stable until the handshake. Stalls indefinitely while out_ready = 0.
  - On out_valid & out_ready, if idx == N_NEURON-1: out_valid <= 0, done <= 1 for one cycle, idx <= 0, go to IDLE.
  - On out_valid & out_ready, otherwise: out_valid <= 0, idx <= idx+1, go to FETCH.
- Latency and throughput:
  - Accept at edge E0 → first out_valid after edge E2.
  - With out_ready held at 1: 3 cycles per neuron; handshakes at E3, E6, …, E(3N).
  - in_ready returns high after edge E(3N).
- Index bounds: idx never exceeds N_NEURON-1 and never wraps. N_NEURON = 1 goes FETCH→EVAL→EMIT→IDLE.
- in_valid while busy is ignored and the vector is not captured; the upstream must hold it.
- No back-to-back overlap: the next vector is accepted no earlier than the edge after the IDLE return.
- Reset mid-layer aborts immediately. No partial result is emitted after reset release; idx restarts at 0.
- dp_* are registered outputs; the datapath combinational path is dp_* → dp_res → out_data register only.

Test Plan:
- Common setup:
  - ROM: w1[k] = 16'h0010*(k+1), w2[k] = 16'h0020*(k+1), b[k] = 16'h0100*(k+1).
  - Stub datapath: dp_res = dp_b ^ dp_d1.
- Nominal layer:
  - Stimulus: N=4, in_d1 = 16'h0003, in_d2 = 16'h0005 accepted at E0, out_ready = 1.
  - Required: out_valid after E2; outputs (idx, data) = (0,16'h0103), (1,16'h0203), (2,16'h0303), (3,16'h0403) at E3/E6/E9/E12.
  - Required: done high for exactly one cycle after E12; in_ready = 1 after E12.
- Backpressure:
  - Stimulus: out_ready = 0 for 10 cycles during neuron 1.
  - Required: out_valid stays 1, out_idx = 1, out_data = 16'h0203 stable; no idx advance; resumes correctly when out_ready returns.
- Busy input:
  - Stimulus: in_valid held with in_d1 = 16'hFFFF during the layer.
  - Required: in_ready = 0, dp_d1 stays 16'h0003; the new vector is accepted only in IDLE.
- Mid-layer reset:
  - Stimulus: assert rst during EVAL of neuron 2.
  - Required: all outputs zero immediately; no output with idx 2 appears; the next vector starts at idx 0.
- Single-neuron config:
  - Stimulus: N_NEURON = 1, out_ready = 1.
  - Required: one output (0, 16'h0103) at E3, then done pulse; back-to-back vectors accepted every 4 cycles.
